// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: conditions the raw PS/2 pins, decodes 11-bit frames
// and queues valid scan codes in a show-ahead FIFO with sticky error flags.
module ps2_keyboard_receiver #(
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_dat,
   input  logic                          rd_en,
   input  logic                          clear_errors,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          parity_error,
   output logic                          framing_error,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   logic          clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
   logic [FW-1:0] filt_cnt_r;
   logic          filt_r, filt_prev_r, fall_r;
   state_t        state_r;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    shift_r;
   logic          par_r;
   logic [TW-1:0] to_cnt_r;
   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;

   logic          stop_seen_s, par_good_s, to_hit_s, push_s, par_ev_s, frm_ev_s;
   logic          pop_s, full_s, wr_ok_s, ovf_ev_s;
   logic [AW-1:0] rd_ptr_inc_s;
   logic [CW-1:0] count_nx_s;
   logic [7:0]    head_nx_s;

   // Pin synchronizers, ps2_clk stability filter and falling-edge strobe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         clk_meta_r  <= 1'b1;
         clk_sync_r  <= 1'b1;
         dat_meta_r  <= 1'b1;
         dat_sync_r  <= 1'b1;
         filt_cnt_r  <= '0;
         filt_r      <= 1'b1;
         filt_prev_r <= 1'b1;
         fall_r      <= 1'b0;
      end else begin
         clk_meta_r  <= ps2_clk;
         clk_sync_r  <= clk_meta_r;
         dat_meta_r  <= ps2_dat;
         dat_sync_r  <= dat_meta_r;
         if (clk_sync_r == filt_r) begin
            filt_cnt_r <= '0;
         end else if (filt_cnt_r == FW'(FILTER_CYCLES - 1)) begin
            filt_r     <= clk_sync_r;
            filt_cnt_r <= '0;
         end else begin
            filt_cnt_r <= filt_cnt_r + FW'(1);
         end
         filt_prev_r <= filt_r;
         fall_r      <= filt_prev_r & ~filt_r;
      end
   end

   // Frame-completion events; these act on the same edge the FSM leaves STOP.
   always_comb begin
      stop_seen_s = fall_r && (state_r == ST_STOP);
      par_good_s  = odd_parity_ok(shift_r, par_r);
      to_hit_s    = (state_r != ST_IDLE) && !fall_r && (to_cnt_r >= TW'(TIMEOUT_CYCLES - 1));
      push_s      = stop_seen_s && dat_sync_r && par_good_s;
      par_ev_s    = stop_seen_s && dat_sync_r && !par_good_s;
      frm_ev_s    = (stop_seen_s && !dat_sync_r) || to_hit_s;
   end

   // Frame FSM with inter-edge timeout.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'd0;
         par_r     <= 1'b0;
         to_cnt_r  <= '0;
      end else begin
         if (fall_r || (state_r == ST_IDLE)) to_cnt_r <= '0;
         else                                to_cnt_r <= to_cnt_r + TW'(1);
         if (to_hit_s) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
         end else if (fall_r) begin
            case (state_r)
               ST_IDLE: begin
                  if (!dat_sync_r) begin
                     state_r   <= ST_DATA;
                     bit_cnt_r <= 3'd0;
                  end
               end
               ST_DATA: begin
                  shift_r   <= {dat_sync_r, shift_r[7:1]};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) state_r <= ST_PARITY;
               end
               ST_PARITY: begin
                  par_r   <= dat_sync_r;
                  state_r <= ST_STOP;
               end
               ST_STOP: state_r <= ST_IDLE;
               default: state_r <= ST_IDLE;
            endcase
         end
      end
   end

   // FIFO next-state: a pop at full frees the slot the push lands in.
   always_comb begin
      pop_s        = rd_en && (fifo_count != '0);
      full_s       = (fifo_count == CW'(FIFO_DEPTH));
      wr_ok_s      = push_s && (!full_s || pop_s);
      ovf_ev_s     = push_s && full_s && !pop_s;
      rd_ptr_inc_s = rd_ptr_r + AW'(1);
      if (wr_ok_s && !pop_s)      count_nx_s = fifo_count + CW'(1);
      else if (!wr_ok_s && pop_s) count_nx_s = fifo_count - CW'(1);
      else                        count_nx_s = fifo_count;
      if (count_nx_s == '0)                      head_nx_s = 8'd0;
      else if (fifo_count <= CW'(1) && wr_ok_s &&
               (pop_s || fifo_count == '0))      head_nx_s = shift_r;
      else if (pop_s)                            head_nx_s = mem_r[rd_ptr_inc_s];
      else                                       head_nx_s = rd_data;
   end

   // FIFO pointers and registered show-ahead head.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         fifo_count <= '0;
         rd_data    <= 8'd0;
         rd_valid   <= 1'b0;
      end else begin
         if (wr_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)   rd_ptr_r <= rd_ptr_inc_s;
         fifo_count <= count_nx_s;
         rd_data    <= head_nx_s;
         rd_valid   <= (count_nx_s != '0);
      end
   end

   // FIFO storage; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (wr_ok_s) mem_r[wr_ptr_r] <= shift_r;
   end

   // Sticky error flags; a new event beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         parity_error  <= par_ev_s | (parity_error  & ~clear_errors);
         framing_error <= frm_ev_s | (framing_error & ~clear_errors);
         overflow      <= ovf_ev_s | (overflow      & ~clear_errors);
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for ps2_keyboard_receiver: frame vectors table plus a
// scoreboard queue of expected scan codes, with hand-written corner sequences.
module tb_ps2_keyboard_receiver;

   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       reset, ps2_clk, ps2_dat, rd_en, clear_errors;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [3:0] fifo_count;
   logic       parity_error, framing_error, overflow;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic       exp_par = 1'b0, exp_frm = 1'b0, exp_ovf = 1'b0;

   typedef struct {
      logic [7:0] code;
      logic       bad_par;
      logic       stop;
      logic       push;
      logic       exp_par;
      logic       exp_frm;
   } vec_t;
   vec_t vecs[3];

   always #10 clk = ~clk;

   ps2_keyboard_receiver dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .rd_en(rd_en), .clear_errors(clear_errors), .rd_data(rd_data),
      .rd_valid(rd_valid), .fifo_count(fifo_count), .parity_error(parity_error),
      .framing_error(framing_error), .overflow(overflow)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag);
      logic [7:0] head;
      head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
      chk({tag, ".rd_valid"},      rd_valid,      exp_q.size() != 0);
      chk({tag, ".fifo_count"},    fifo_count,    exp_q.size());
      chk({tag, ".rd_data"},       rd_data,       head);
      chk({tag, ".parity_error"},  parity_error,  exp_par);
      chk({tag, ".framing_error"}, framing_error, exp_frm);
      chk({tag, ".overflow"},      overflow,      exp_ovf);
   endtask

   function automatic logic odd_par(input logic [7:0] c);
      return ~^c;
   endfunction

   // mode 0: plain, 1: pop on the STOP fall cycle, 2: check push latency
   task automatic send_bits(input logic [10:0] fr, input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         ps2_dat = fr[i];
         repeat (HALF) tick;
         ps2_clk = 1'b0;
         if (i == 10 && mode == 1) begin
            repeat (11) tick;
            chk("simul_pop_data", rd_data, exp_q[0]);
            void'(exp_q.pop_front());
            rd_en = 1'b1;
            tick;
            rd_en = 1'b0;
            repeat (HALF - 12) tick;
         end else if (i == 10 && mode == 2) begin
            repeat (11) tick;
            chk("latency_before", rd_valid, 1'b0);
            tick;
            chk("latency_after", rd_valid, 1'b1);
            repeat (HALF - 12) tick;
         end else begin
            repeat (HALF) tick;
         end
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
      repeat (20) tick;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic par, input logic stop, input int mode);
      send_bits({stop, par, code, 1'b0}, 11, mode);
   endtask

   task automatic send_good(input logic [7:0] code);
      send_frame(code, odd_par(code), 1'b1, 0);
   endtask

   task automatic do_pop(input string tag);
      chk({tag, ".pop_data"}, rd_data, exp_q[0]);
      void'(exp_q.pop_front());
      rd_en = 1'b1;
      tick;
      rd_en = 1'b0;
   endtask

   task automatic pulse_clear;
      clear_errors = 1'b1;
      tick;
      clear_errors = 1'b0;
   endtask

   initial begin
      vecs[0] = '{code: 8'h1C, bad_par: 1'b0, stop: 1'b1, push: 1'b1, exp_par: 1'b0, exp_frm: 1'b0};
      vecs[1] = '{code: 8'hF0, bad_par: 1'b1, stop: 1'b1, push: 1'b0, exp_par: 1'b1, exp_frm: 1'b0};
      vecs[2] = '{code: 8'hF0, bad_par: 1'b0, stop: 1'b0, push: 1'b0, exp_par: 1'b1, exp_frm: 1'b1};

      reset = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_en = 1'b0; clear_errors = 1'b0;
      repeat (3) tick;
      check_out("reset_state");
      reset = 1'b1;
      repeat (5) tick;

      // Table: good frame, bad parity, bad stop bit
      for (int i = 0; i < 3; i++) begin
         send_frame(vecs[i].code, odd_par(vecs[i].code) ^ vecs[i].bad_par, vecs[i].stop,
                    (i == 0) ? 2 : 0);
         if (vecs[i].push) exp_q.push_back(vecs[i].code);
         exp_par = vecs[i].exp_par;
         exp_frm = vecs[i].exp_frm;
         check_out($sformatf("vec%0d", i));
         if (exp_q.size() != 0) begin
            do_pop($sformatf("vec%0d", i));
            check_out($sformatf("vec%0d_popped", i));
         end
      end
      pulse_clear;
      exp_par = 1'b0; exp_frm = 1'b0;
      check_out("clear");

      // Timeout: start plus three data bits, then silence
      send_bits({1'b1, 1'b0, 8'h05, 1'b0}, 4, 0);
      repeat (49000) tick;
      check_out("timeout_early");
      repeat (1200) tick;
      exp_frm = 1'b1;
      check_out("timeout");
      send_good(8'h1C);
      exp_q.push_back(8'h1C);
      check_out("after_timeout");
      do_pop("after_timeout");
      pulse_clear;
      exp_frm = 1'b0;

      // Fill past capacity
      for (int c = 1; c <= 9; c++) begin
         send_good(8'(c));
         if (exp_q.size() < 8) exp_q.push_back(8'(c));
         else                  exp_ovf = 1'b1;
      end
      check_out("full");
      for (int k = 0; k < 8; k++) do_pop("drain_full");
      check_out("drained");
      send_good(8'h0A); exp_q.push_back(8'h0A);
      send_good(8'h0B); exp_q.push_back(8'h0B);
      check_out("wrap");
      pulse_clear;
      exp_ovf = 1'b0;
      check_out("clear_ovf");

      // Simultaneous push/pop at full
      for (int c = 8'h10; c <= 8'h15; c++) begin
         send_good(8'(c));
         exp_q.push_back(8'(c));
      end
      check_out("refill");
      send_frame(8'h2A, odd_par(8'h2A), 1'b1, 1);
      exp_q.push_back(8'h2A);
      check_out("simul");
      for (int k = 0; k < 8; k++) do_pop("drain_simul");
      check_out("drained2");

      // Short ps2_clk glitch with data low must not start a frame
      ps2_dat = 1'b0; ps2_clk = 1'b0;
      repeat (3) tick;
      ps2_clk = 1'b1; ps2_dat = 1'b1;
      repeat (30) tick;
      check_out("glitch");
      send_good(8'h1C);
      exp_q.push_back(8'h1C);
      check_out("after_glitch");
      send_frame(8'h55, ~odd_par(8'h55), 1'b1, 0);
      exp_par = 1'b1;
      check_out("pre_reset");

      // Reset mid-frame clears everything and raises no flag
      send_bits({1'b1, 1'b0, 8'hA3, 1'b0}, 5, 0);
      reset = 1'b0;
      tick;
      reset = 1'b1;
      exp_q.delete();
      exp_par = 1'b0;
      check_out("mid_reset");
      repeat (5) tick;
      send_good(8'h1C);
      exp_q.push_back(8'h1C);
      check_out("after_reset");
      do_pop("after_reset");
      tick;
      check_out("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
